// File: rtl/cac_tx_pkg.sv
// Shared constants, state encoding and parity helper for the transmit-side CAC framer.
// Optional parity symbol per word is enabled with `CAC_TX_PARITY_EN.
package cac_tx_pkg;

   localparam int DBLEN16 = 12;
   localparam int WORD_W  = 33;
   localparam int CHUNK_W = 11;

   // Codewords 2048..3193 are legal for the encoder but never carry payload.
   localparam logic [DBLEN16-1:0] SYM_IDLE     = 12'd3100;
   localparam logic [DBLEN16-1:0] SYM_SYNC     = 12'd3150;
   localparam logic [DBLEN16-1:0] SYM_PAR_BASE = 12'd2048;
   localparam logic [DBLEN16-1:0] SYM_MAX      = 12'd3193;

   typedef enum logic [2:0] {
      ST_PRE,
      ST_IDLE,
      ST_D0,
      ST_D1,
      ST_D2,
`ifdef CAC_TX_PARITY_EN
      ST_PAR,
`endif
      ST_RSYNC
   } state_t;

`ifdef CAC_TX_PARITY_EN
   function automatic logic [9:0] word_parity(input logic [WORD_W-1:0] w);
      return w[9:0] ^ w[20:11] ^ w[31:22];
   endfunction
`endif

endpackage

// File: rtl/cac_sym_mux.sv
// Combinational choice of the symbol for the current framer state.
// Emits the parity symbol in ST_PAR when `CAC_TX_PARITY_EN is defined.
module cac_sym_mux
   import cac_tx_pkg::*;
(
   input  state_t              state,
   input  logic [WORD_W-1:0]   hold,
   output logic [DBLEN16-1:0]  sym,
   output logic                is_data
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      sym     = SYM_IDLE;
      is_data = 1'b0;
      case (state)
         ST_PRE, ST_RSYNC: sym = SYM_SYNC;
         ST_D0: begin
            sym     = {1'b0, hold[CHUNK_W-1:0]};
            is_data = 1'b1;
         end
         ST_D1: begin
            sym     = {1'b0, hold[2*CHUNK_W-1:CHUNK_W]};
            is_data = 1'b1;
         end
         ST_D2: begin
            sym     = {1'b0, hold[3*CHUNK_W-1:2*CHUNK_W]};
            is_data = 1'b1;
         end
`ifdef CAC_TX_PARITY_EN
         ST_PAR: sym = SYM_PAR_BASE | {2'b00, word_parity(hold)};
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/cac_tx_framer_16.sv
// Splits 33-bit payload words into three 11-bit symbols for DPS_encoder_16, with SYNC/IDLE fill.
// Define `CAC_TX_PARITY_EN to append one parity symbol after each word.
module cac_tx_framer_16
   import cac_tx_pkg::*;
#(
   parameter int SYNC_LEN    = 4,
   parameter int SYNC_PERIOD = 256
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [WORD_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [DBLEN16-1:0]  sym_out,
   output logic                sym_is_data
);

`ifdef CAC_TX_PARITY_EN
   localparam state_t LAST_ST = ST_PAR;
`else
   localparam state_t LAST_ST = ST_D2;
`endif

   state_t              state;
   logic [3:0]          pre_cnt;
   logic [15:0]         word_cnt;
   logic [WORD_W-1:0]   hold;
   logic [DBLEN16-1:0]  mux_sym;
   logic                mux_is_data;
   logic                is_last;
   logic                resync_due;
   logic                accept;

   assign is_last    = (state == LAST_ST);
   assign resync_due = (word_cnt == 16'(SYNC_PERIOD));
   assign in_ready   = !reset && ((state == ST_IDLE) || (is_last && !resync_due));
   assign accept     = in_valid && in_ready;

   cac_sym_mux u_sym_mux (
      .state   (state),
      .hold    (hold),
      .sym     (mux_sym),
      .is_data (mux_is_data)
   );

   // sym_out trails the state by one cycle: the symbol for a state is registered on leaving it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_PRE;
         pre_cnt     <= '0;
         word_cnt    <= '0;
         hold        <= '0;
         sym_out     <= SYM_SYNC;
         sym_is_data <= 1'b0;
      end else begin
         sym_out     <= mux_sym;
         sym_is_data <= mux_is_data;
         if (accept) begin
            hold     <= in_data;
            word_cnt <= word_cnt + 16'd1;
         end
         if (is_last) begin
            if (accept) begin
               state <= ST_D0;
            end else if (resync_due) begin
               state    <= ST_RSYNC;
               word_cnt <= '0;
            end else begin
               state <= ST_IDLE;
            end
         end else begin
            case (state)
               ST_PRE: begin
                  if (pre_cnt == 4'(SYNC_LEN - 1)) state <= ST_IDLE;
                  else                             pre_cnt <= pre_cnt + 4'd1;
               end
               ST_IDLE:  if (accept) state <= ST_D0;
               ST_D0:    state <= ST_D1;
               ST_D1:    state <= ST_D2;
`ifdef CAC_TX_PARITY_EN
               ST_D2:    state <= ST_PAR;
`endif
               ST_RSYNC: state <= ST_IDLE;
               default:  state <= ST_PRE;
            endcase
         end
      end
   end

endmodule
